// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: requester indices, default widths and the write-request type
// shared by the register-file write arbiter and its holding buffers.
package rf_arb_pkg;
    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;
    localparam int RF_AW = 5;
    localparam int RF_DW = 32;
    typedef struct packed {
        logic [RF_AW-1:0] rd;
        logic [RF_DW-1:0] data;
    } wr_req_t;
endpackage

// File: rtl/rf_wr_buffer.sv
// rf_wr_buffer: one-entry valid/ready holding register for a writeback source;
// a granted entry can be refilled on the same edge it drains.
module rf_wr_buffer
    import rf_arb_pkg::*;
#(
    parameter type req_t = wr_req_t
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_valid,
    input  req_t i_req,
    input  logic i_grant,
    output logic o_ready,
    output logic o_cap,
    output logic o_valid,
    output req_t o_req
);
    assign o_ready = ~o_valid | i_grant;
    assign o_cap   = i_valid & o_ready;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_req   <= '0;
        end else begin
            if (o_cap) o_req <= i_req;
            o_valid <= o_cap | (o_valid & ~i_grant);
        end
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: age-ordered, round-robin tie-broken sharing of the RF write
// port between ALU and load writeback. Define RFARB_SCOREBOARD_EN for o_pending.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int AW   = RF_AW,
    parameter int DW   = RF_DW,
    parameter int NREG = 2**AW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_alu_valid,
    input  logic [AW-1:0] i_alu_reg,
    input  logic [DW-1:0] i_alu_data,
    output logic          o_alu_ready,
    input  logic          i_mem_valid,
    input  logic [AW-1:0] i_mem_reg,
    input  logic [DW-1:0] i_mem_data,
    output logic          o_mem_ready,
    output logic          o_RegWrite,
    output logic [AW-1:0] o_Write_reg,
    output logic [DW-1:0] o_Write_data,
    output logic          o_idle
`ifdef RFARB_SCOREBOARD_EN
    ,
    output logic [NREG-1:0] o_pending
`endif
);
    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } req_t;

    req_t       buf_q [2];
    req_t       sel;
    logic [1:0] buf_v, grant, cap, ready;
    logic       age_q, tie_q, rr_q;

    rf_wr_buffer #(.req_t(req_t)) u_alu_buf (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_alu_valid),
        .i_req   ('{rd: i_alu_reg, data: i_alu_data}),
        .i_grant (grant[REQ_ALU]),
        .o_ready (ready[REQ_ALU]),
        .o_cap   (cap[REQ_ALU]),
        .o_valid (buf_v[REQ_ALU]),
        .o_req   (buf_q[REQ_ALU])
    );

    rf_wr_buffer #(.req_t(req_t)) u_mem_buf (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_mem_valid),
        .i_req   ('{rd: i_mem_reg, data: i_mem_data}),
        .i_grant (grant[REQ_MEM]),
        .o_ready (ready[REQ_MEM]),
        .o_cap   (cap[REQ_MEM]),
        .o_valid (buf_v[REQ_MEM]),
        .o_req   (buf_q[REQ_MEM])
    );

    // age_q=1: load entry is older; tie_q: both entries captured on one edge
    assign grant[REQ_MEM] = buf_v[REQ_MEM] & (~buf_v[REQ_ALU] | (tie_q ? rr_q : age_q));
    assign grant[REQ_ALU] = buf_v[REQ_ALU] & ~grant[REQ_MEM];
    assign sel            = grant[REQ_MEM] ? buf_q[REQ_MEM] : buf_q[REQ_ALU];

    assign o_alu_ready  = ready[REQ_ALU];
    assign o_mem_ready  = ready[REQ_MEM];
    assign o_Write_reg  = |grant ? sel.rd : '0;
    assign o_Write_data = |grant ? sel.data : '0;
    assign o_RegWrite   = |grant & (sel.rd != '0) & (int'(sel.rd) < NREG);
    assign o_idle       = ~|buf_v;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            age_q <= 1'b0;
            tie_q <= 1'b0;
            rr_q  <= 1'b0;
        end else begin
            if (&buf_v & tie_q) rr_q <= ~rr_q;
            if (&cap) begin
                tie_q <= 1'b1;
            end else if (|cap) begin
                tie_q <= 1'b0;
                age_q <= cap[REQ_ALU];
            end
        end
    end

`ifdef RFARB_SCOREBOARD_EN
    always_comb begin
        o_pending = '0;
        for (int k = 0; k < 2; k++)
            if (buf_v[k]) o_pending[buf_q[k].rd] = 1'b1;
        o_pending[0] = 1'b0;
    end
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed self-checking bench for rf_write_arbiter
// (covers o_pending when RFARB_SCOREBOARD_EN is defined).
module tb_rf_write_arbiter;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_alu_valid = 1'b0;
    logic [4:0]  i_alu_reg = '0;
    logic [31:0] i_alu_data = '0;
    logic        o_alu_ready;
    logic        i_mem_valid = 1'b0;
    logic [4:0]  i_mem_reg = '0;
    logic [31:0] i_mem_data = '0;
    logic        o_mem_ready;
    logic        o_RegWrite;
    logic [4:0]  o_Write_reg;
    logic [31:0] o_Write_data;
    logic        o_idle;
`ifdef RFARB_SCOREBOARD_EN
    logic [31:0] o_pending;
`endif
    int n_chk = 0;
    int n_fail = 0;

    rf_write_arbiter dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_alu_valid  (i_alu_valid),
        .i_alu_reg    (i_alu_reg),
        .i_alu_data   (i_alu_data),
        .o_alu_ready  (o_alu_ready),
        .i_mem_valid  (i_mem_valid),
        .i_mem_reg    (i_mem_reg),
        .i_mem_data   (i_mem_data),
        .o_mem_ready  (o_mem_ready),
        .o_RegWrite   (o_RegWrite),
        .o_Write_reg  (o_Write_reg),
        .o_Write_data (o_Write_data),
        .o_idle       (o_idle)
`ifdef RFARB_SCOREBOARD_EN
        ,
        .o_pending    (o_pending)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic wr(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] d);
        chk({tag, "_we"}, 64'(o_RegWrite), 64'(we));
        chk({tag, "_reg"}, 64'(o_Write_reg), 64'(rd));
        chk({tag, "_data"}, 64'(o_Write_data), 64'(d));
    endtask

    task automatic reset_outs(input string tag);
        wr(tag, 1'b0, 5'd0, 32'd0);
        chk({tag, "_alu_rdy"}, 64'(o_alu_ready), 64'd1);
        chk({tag, "_mem_rdy"}, 64'(o_mem_ready), 64'd1);
        chk({tag, "_idle"}, 64'(o_idle), 64'd1);
`ifdef RFARB_SCOREBOARD_EN
        chk({tag, "_pending"}, 64'(o_pending), 64'd0);
`endif
    endtask

    initial begin
        int ai, mi, nw, cyc;
        logic acc_a, acc_m;
        #3 reset_outs("rst");
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // single ALU write r5
        i_alu_valid = 1'b1; i_alu_reg = 5'd5; i_alu_data = 32'hDEAD_BEEF;
        chk("t1_rdy", 64'(o_alu_ready), 64'd1);
        step();
        i_alu_valid = 1'b0;
        wr("t1", 1'b1, 5'd5, 32'hDEAD_BEEF);
        chk("t1_busy", 64'(o_idle), 64'd0);
`ifdef RFARB_SCOREBOARD_EN
        chk("t1_pending", 64'(o_pending), 64'h20);
`endif
        step();
        wr("t1_done", 1'b0, 5'd0, 32'd0);
        chk("t1_idle", 64'(o_idle), 64'd1);

        // same-edge tie, pointer at ALU
        i_alu_valid = 1'b1; i_alu_reg = 5'd3; i_alu_data = 32'd1;
        i_mem_valid = 1'b1; i_mem_reg = 5'd3; i_mem_data = 32'd2;
        step();
        i_alu_valid = 1'b0; i_mem_valid = 1'b0;
        wr("t2_a", 1'b1, 5'd3, 32'd1);
        chk("t2_mem_stall", 64'(o_mem_ready), 64'd0);
        chk("t2_alu_rdy", 64'(o_alu_ready), 64'd1);
        step();
        wr("t2_m", 1'b1, 5'd3, 32'd2);
        step();
        chk("t2_idle", 64'(o_idle), 64'd1);

        // pointer now at MEM: tie r9/r10, then MEM r7 older than ALU r7
        i_alu_valid = 1'b1; i_alu_reg = 5'd9;  i_alu_data = 32'h99;
        i_mem_valid = 1'b1; i_mem_reg = 5'd10; i_mem_data = 32'h10;
        step();
        wr("t3_tie", 1'b1, 5'd10, 32'h10);
        i_alu_valid = 1'b0;
        i_mem_reg = 5'd7; i_mem_data = 32'h77;
        step();
        wr("t3_old_alu", 1'b1, 5'd9, 32'h99);
        chk("t3_mem_stall", 64'(o_mem_ready), 64'd0);
        i_mem_valid = 1'b0;
        i_alu_valid = 1'b1; i_alu_reg = 5'd7; i_alu_data = 32'hA7;
        step();
        i_alu_valid = 1'b0;
        wr("t3_mem_r7", 1'b1, 5'd7, 32'h77);
        chk("t3_alu_stall", 64'(o_alu_ready), 64'd0);
        step();
        wr("t3_alu_r7", 1'b1, 5'd7, 32'hA7);
        step();
        chk("t3_idle", 64'(o_idle), 64'd1);

        // write to r0 is swallowed
        i_alu_valid = 1'b1; i_alu_reg = 5'd0; i_alu_data = 32'hFFFF_FFFF;
        step();
        i_alu_valid = 1'b0;
        wr("t4", 1'b0, 5'd0, 32'hFFFF_FFFF);
        chk("t4_rdy", 64'(o_alu_ready), 64'd1);
`ifdef RFARB_SCOREBOARD_EN
        chk("t4_pending", 64'(o_pending), 64'd0);
`endif
        step();
        chk("t4_idle", 64'(o_idle), 64'd1);

        // fresh pointer, then both requesters streaming 5 writes each
        i_rst_n = 1'b0;
        step();
        i_rst_n = 1'b1;
        ai = 0; mi = 0; nw = 0; cyc = 0;
        for (int c = 0; c < 20 && nw < 10; c++) begin
            i_alu_valid = ai < 5; i_alu_reg = 5'(ai + 1);  i_alu_data = 32'hA00 + 32'(ai);
            i_mem_valid = mi < 5; i_mem_reg = 5'(mi + 11); i_mem_data = 32'hB00 + 32'(mi);
            acc_a = i_alu_valid & o_alu_ready;
            acc_m = i_mem_valid & o_mem_ready;
            step();
            if (acc_a) ai++;
            if (acc_m) mi++;
            if (o_RegWrite) begin
                if (nw % 2 == 0) wr("t5_alu", 1'b1, 5'(nw / 2 + 1), 32'hA00 + 32'(nw / 2));
                else wr("t5_mem", 1'b1, 5'(nw / 2 + 11), 32'hB00 + 32'(nw / 2));
                nw++;
            end
            cyc = c + 1;
        end
        i_alu_valid = 1'b0; i_mem_valid = 1'b0;
        chk("t5_count", 64'(nw), 64'd10);
        chk("t5_cycles", 64'(cyc), 64'd10);
        step();
        chk("t5_idle", 64'(o_idle), 64'd1);
        chk("t5_no_dup", 64'(o_RegWrite), 64'd0);

        // async reset with both buffers full
        i_alu_valid = 1'b1; i_alu_reg = 5'd20; i_alu_data = 32'h2020;
        i_mem_valid = 1'b1; i_mem_reg = 5'd21; i_mem_data = 32'h2121;
        step();
        i_alu_valid = 1'b0; i_mem_valid = 1'b0;
        chk("t6_full", 64'(o_idle), 64'd0);
`ifdef RFARB_SCOREBOARD_EN
        chk("t6_pending", 64'(o_pending), 64'h0030_0000);
`endif
        #2 i_rst_n = 1'b0;
        #1 reset_outs("t6_rst");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step();
        reset_outs("t6_after1");
        step();
        chk("t6_after2_we", 64'(o_RegWrite), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port (RegWrite, Write_reg, Write_data) between two multi-cycle CPU writeback sources: ALU result (requester 0) and memory load (requester 1).
- Each requester has a valid/ready handshake and a one-entry holding buffer.
- Arbitration is age-ordered with round-robin tie-break; at most one RF write per cycle.
- Sits between the multi-cycle control/datapath and the register file; the RF itself is unchanged.

Parameters:
- AW, 5, register address width
- DW, 32, data width
- NREG, 32, number of architectural registers (2**AW)

Ports:
- i_clk  in  1  clock, posedge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_alu_valid  in  1  ALU write request
- i_alu_reg  in  AW  ALU destination register
- i_alu_data  in  DW  ALU result
- o_alu_ready  out  1  ALU buffer can accept
- i_mem_valid  in  1  load write request
- i_mem_reg  in  AW  load destination register
- i_mem_data  in  DW  load data
- o_mem_ready  out  1  load buffer can accept
- o_RegWrite  out  1  RF write enable
- o_Write_reg  out  AW  RF write address
- o_Write_data  out  DW  RF write data
- o_idle  out  1  both buffers empty

Behaviour:
- Reset (async, i_rst_n=0): both buffers empty; age flag = 0; round-robin pointer = 0 (ALU preferred). Outputs: o_RegWrite=0, o_Write_reg=0, o_Write_data=0, o_alu_ready=1, o_mem_ready=1, o_idle=1.
- Reset asserted mid-operation drops buffered writes; no RF write issues for them.
- Buffer k:
  - Fields: valid bit, reg, data.
  - Capture at posedge when i_k_valid & o_k_ready.
  - o_k_ready = ~buf_valid[k] | grant[k]. A full buffer that is granted this cycle accepts a new request on the same edge, giving 1 write/cycle/requester throughput.
- Grant, combinational from the buffers only (no input-to-output path):
  - Only one buffer valid: that buffer is granted.
  - Both valid, different capture edges: the older buffer is granted (age flag records which was captured first).
  - Both valid, captured on the same edge: the round-robin pointer decides.
  - Granted buffer clears at the next posedge unless refilled on that edge.
  - Round-robin pointer toggles away from a requester after each same-edge tie it wins.
- Outputs:
  - o_RegWrite = grant_any & (granted reg != 0). A write to r0 consumes a grant but never asserts o_RegWrite.
  - o_Write_reg and o_Write_data come from the granted buffer; they are 0 when there is no grant.
- Latency: request accepted at edge N → o_RegWrite high during cycle N+1 if granted → RF updated at edge N+1 end (posedge N+2 relative to request). A losing request waits exactly one extra cycle.
- Ordering guarantee: two writes to the same register from different requesters reach the RF in acceptance order. Same-edge acceptance is ordered by the pointer.
- Starvation: none. The older entry always wins, so the maximum wait is 1 cycle.
- o_idle = ~buf_valid[0] & ~buf_valid[1].

Optional Feature:
- RFARB_SCOREBOARD_EN defined:
  - Adds output o_pending [NREG-1:0].
  - Bit r = 1 while any buffer holds a write to register r (r≠0); bit 0 is always 0.
  - Used by control to stall reads of in-flight registers.
  - Combinational OR of the decoded buffer addresses.
- Undefined: port absent, no decode logic.

Decomposition:
- Shared package rf_arb_pkg:
  - REQ_ALU=0, REQ_MEM=1 constants.
  - AW/DW defaults.
  - Write-request struct/typedef {reg, data}.
- Natural sub-module: rf_wr_buffer, the one-entry valid/ready holding register, instantiated twice.
- Arbiter and age logic stay in the top level.

Test Plan:
- Reset then ALU writes r5=32'hDEAD_BEEF alone → o_RegWrite=1, o_Write_reg=5, o_Write_data=DEADBEEF one cycle after accept; o_idle returns to 1.
- ALU r3=1 and MEM r3=2 valid on the same edge, pointer=ALU → cycle N+1 writes r3=1, cycle N+2 writes r3=2; o_mem_ready=0 during N+1.
- MEM r7 accepted at edge N, ALU r7 at N+1 while MEM still stalled → MEM write issues first; final r7 = ALU data.
- ALU write to r0 with data FFFFFFFF → o_RegWrite stays 0, buffer drains in one cycle, o_alu_ready stays 1.
- Both requesters valid every cycle for 10 cycles → exactly 10 RF writes, alternating ALU/MEM, no lost or duplicated entry.
- Reset asserted while both buffers are full → outputs go to reset values immediately; after release no write issues; with RFARB_SCOREBOARD_EN, o_pending=0.
